// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: 2-bit saturating-counter branch history table with IF/ID/EX tracking
// Ports:
//   clk, rst                 clock, async active-high reset
//   if_pc, if_is_branch      fetch-stage lookup request
//   pred_pcsrc               fetch-stage prediction (combinational)
//   stall, flush             pipeline control for the tracking stages
//   act_pcsrc                EX-stage resolved outcome
//   ex_is_branch, ex_pred_pcsrc, mispredict, mispredict_cnt  EX-stage status
module branch_predictor_bht #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_is_branch,
  output logic        pred_pcsrc,
  input  logic        stall,
  input  logic        flush,
  input  logic        act_pcsrc,
  output logic        ex_is_branch,
  output logic        ex_pred_pcsrc,
  output logic        mispredict,
  output logic [15:0] mispredict_cnt
);
  localparam int N = 1 << IDX_BITS;
  logic [1:0] r_bht [N];
  logic [IDX_BITS-1:0] w_idx, r_ifid_idx, r_idex_idx;
  logic r_ifid_v, r_ifid_p, r_idex_v, r_idex_p;
  logic [1:0] w_ctr, w_ctr_nxt;
  logic [15:0] r_cnt;
  logic w_upd;
  assign w_idx = if_pc[IDX_BITS+1:2];
  assign pred_pcsrc = if_is_branch & r_bht[w_idx][1];
  assign ex_is_branch = r_idex_v;
  assign ex_pred_pcsrc = r_idex_p;
  assign mispredict = r_idex_v & (act_pcsrc ^ r_idex_p);
  assign mispredict_cnt = r_cnt;
  // The update is gated only by stall: the EX branch is older than anything a flush squashes.
  assign w_upd = r_idex_v & ~stall;
  assign w_ctr = r_bht[r_idex_idx];
  assign w_ctr_nxt = act_pcsrc ? ((w_ctr == 2'b11) ? w_ctr : w_ctr + 2'd1)
                               : ((w_ctr == 2'b00) ? w_ctr : w_ctr - 2'd1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_bht[i] <= 2'b01;
    end else if (w_upd) begin
      r_bht[r_idex_idx] <= w_ctr_nxt;
    end
  end
  // Flush clears whole entries so squashed slots present as all-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      r_ifid_v   <= 1'b0;
      r_ifid_p   <= 1'b0;
      r_ifid_idx <= '0;
      r_idex_v   <= 1'b0;
      r_idex_p   <= 1'b0;
      r_idex_idx <= '0;
    end else if (!stall) begin
      r_ifid_v   <= if_is_branch;
      r_ifid_p   <= pred_pcsrc;
      r_ifid_idx <= w_idx;
      r_idex_v   <= r_ifid_v;
      r_idex_p   <= r_ifid_p;
      r_idex_idx <= r_ifid_idx;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (mispredict && !stall && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  end
endmodule

// File: doc/branch_predictor_bht.md
BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

Interface
REQ-001 The block SHALL have one parameter, IDX_BITS, default 4, giving the table index width; the table holds 2^IDX_BITS entries.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- if_pc  in  32  fetch-stage PC
- if_is_branch  in  1  fetch-stage instruction is a conditional branch
- pred_pcsrc  out  1  fetch-stage prediction (1 = taken)
- stall  in  1  pipeline stall; holds the tracking registers
- flush  in  1  squashes the IF/ID and ID/EX tracking entries
- act_pcsrc  in  1  EX-stage resolved branch outcome (1 = taken)
- ex_is_branch  out  1  valid branch tracked in EX
- ex_pred_pcsrc  out  1  prediction made for the EX-stage branch; feeds the misprediction selector
- mispredict  out  1  EX-stage branch outcome differs from its prediction
- mispredict_cnt  out  16  saturating count of mispredictions

Function
REQ-003 The table SHALL hold one 2-bit saturating counter per entry, with encodings 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-004 The lookup index SHALL be if_pc[IDX_BITS+1:2].
REQ-005 pred_pcsrc SHALL be combinational and equal to if_is_branch AND counter[index] bit 1.
REQ-006 Two tracking stages (IF/ID, ID/EX) SHALL each hold {valid, pred, idx}.
- On a clock edge with stall=0 and flush=0: IF/ID <= {if_is_branch, pred_pcsrc, index}; ID/EX <= IF/ID.
REQ-007 When stall=1 and flush=0, both tracking stages SHALL hold their values.
REQ-008 When flush=1, both valid bits SHALL clear on the edge, regardless of stall (flush wins).
REQ-009 ex_is_branch SHALL equal ID/EX.valid and ex_pred_pcsrc SHALL equal ID/EX.pred.
- Latency from fetch lookup to EX visibility is 2 unstalled cycles.
REQ-010 mispredict SHALL be combinational and equal to ex_is_branch AND (act_pcsrc XOR ex_pred_pcsrc).
REQ-011 Counter update SHALL occur on an edge where ex_is_branch=1 and stall=0.
- The counter at ID/EX.idx increments if act_pcsrc=1 and decrements otherwise.
- It saturates at 11 and 00.
REQ-012 The update SHALL still occur when flush=1 on that edge, since the branch in EX is older than the flushed entries.
REQ-013 When a lookup and an update hit the same index in the same cycle, the lookup SHALL return the pre-update value; the new value is visible from the next cycle.
REQ-014 mispredict_cnt SHALL increment by 1 on each edge where mispredict=1 and stall=0, and SHALL saturate at 16'hFFFF.
REQ-015 With stall=1, no counter update and no mispredict_cnt increment SHALL occur; mispredict remains combinationally valid.
REQ-016 An X or don't-care on act_pcsrc when ex_is_branch=0 SHALL have no effect on any state.

Reset
REQ-017 While rst=1, all table counters SHALL be set to 01 (weak-NT), regardless of clk.
REQ-018 While rst=1, both tracking valid bits SHALL be 0, with pred and idx at 0.
REQ-019 While rst=1, mispredict_cnt SHALL be 0.
REQ-020 After reset, outputs SHALL be: pred_pcsrc=0, ex_is_branch=0, ex_pred_pcsrc=0, mispredict=0.
REQ-021 Reset asserted mid-operation SHALL discard in-flight tracking entries and any pending update on that edge.
REQ-022 The first clock edge after rst deasserts SHALL be a normal operating edge.

Verification
REQ-023 Reset, then branch at if_pc=0x40 (idx 0) -> pred_pcsrc=0; two cycles later ex_is_branch=1, ex_pred_pcsrc=0; act_pcsrc=1 -> mispredict=1, counter[0] becomes 10, mispredict_cnt=1.
REQ-024 Repeat the branch at 0x40 with act_pcsrc=1 four times -> predictions 0,1,1,1; counter[0] saturates at 11; mispredict_cnt=1.
REQ-025 Branch in EX (idx 3, pred 0, act 1) with flush=1 on the same edge -> counter[3] updates 01->10; both tracking valids clear; ex_is_branch=0 next cycle.
REQ-026 stall=1 for 3 cycles with a mispredicting branch in EX -> mispredict stays 1, counter and mispredict_cnt unchanged; on the first unstalled edge both update once only.
REQ-027 Same-index lookup and update (if_pc idx 5, EX idx 5, counter 01, act 1) -> pred_pcsrc=0 this cycle; pred_pcsrc=1 the next cycle for the same PC.
REQ-028 Force mispredict_cnt to 0xFFFF via 65535 mispredictions (or a backdoor preload) -> a further mispredict leaves it at 0xFFFF; then assert rst asynchronously mid-cycle -> all outputs reach their reset values before the next edge.
